avk_cap_sequencer: RTL and testbench

//  Measurement sequencer for the AVK capacitance front end at 4 MHz.

---
 rtl/avk_cap_sequencer_pkg.sv | 15 +
 rtl/avk_cap_sequencer_if.sv | 24 ++
 rtl/avk_cap_sequencer_debounce.sv | 41 ++++
 rtl/avk_cap_sequencer.sv | 155 +++++++++++++++
 tb/tb_avk_cap_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/avk_cap_sequencer_pkg.sv
// Shared types and default timing constants for the AVK capacitance sequencer.
// Defaults assume the 4 MHz system clock.
package avk_cap_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHARGE    = 2'd1,
      DISCHARGE = 2'd2,
      REPORT    = 2'd3
   } cap_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 400;
   localparam int TIMEOUT_CYCLES_DEF  = 12_000_000;

endpackage

// File: rtl/avk_cap_sequencer_if.sv
// Host-side control/result bundle of the capacitance sequencer.
// The host drives requests through the master modport; the sequencer answers through slave.
interface avk_cap_sequencer_if #(
   parameter int CNT_W = 24
);
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic             err_phase;
   logic [CNT_W-1:0] charge_time;
   logic [CNT_W-1:0] discharge_time;

   modport master (
      output start, abort,
      input  busy, done, timeout_err, err_phase, charge_time, discharge_time
   );

   modport slave (
      input  start, abort,
      output busy, done, timeout_err, err_phase, charge_time, discharge_time
   );
endinterface

// File: rtl/avk_cap_sequencer_debounce.sv
// Comparator conditioner: 2-FF synchronizer followed by a stability down-counter.
// Raw edge to accepted edge is a fixed DEBOUNCE_CYCLES+2 clocks.
module avk_debounce #(
   parameter int DEBOUNCE_CYCLES = 400,
   parameter bit RESET_VAL       = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] RELOAD = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [DW-1:0] cnt;

   // Any sample matching the accepted level restarts the window, so only an
   // unbroken run of DEBOUNCE_CYCLES differing samples flips the output.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1 <= RESET_VAL;
         sync_q2 <= RESET_VAL;
         cnt     <= RELOAD;
         level   <= RESET_VAL;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         if (sync_q2 == level) begin
            cnt <= RELOAD;
         end else if (cnt == '0) begin
            level <= sync_q2;
            cnt   <= RELOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/avk_cap_sequencer.sv
// AVK capacitance measurement sequencer: charge until the upper comparator trips,
// discharge until the lower one trips, report both phase durations.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start, results held
//   CHARGE    | reference=1, counting until pos_db=1 or timeout
//   DISCHARGE | reference=0, counting until neg_db=0 or timeout
//   REPORT    | one-cycle done pulse, results/error valid
module avk_cap_sequencer
   import avk_cap_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W           = 24
) (
   input  logic               clock,
   input  logic               reset,
   avk_cap_sequencer_if.slave host,
   input  logic               pos_comparator,
   input  logic               neg_comparator,
   output logic               reference
);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);

   cap_state_t       state;
   cap_state_t       state_nxt;
   logic             pos_db;
   logic             neg_db;
   logic             phase_timeout;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic             err_phase;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] charge_time;
   logic [CNT_W-1:0] discharge_time;

   avk_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
   ) u_pos_db (
      .clock (clock),
      .reset (reset),
      .raw   (pos_comparator),
      .level (pos_db)
   );

   avk_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_neg_db (
      .clock (clock),
      .reset (reset),
      .raw   (neg_comparator),
      .level (neg_db)
   );

   assign phase_timeout = (cnt == TIMEOUT_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (host.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (host.start) state_nxt = CHARGE;
            CHARGE: begin
               if (pos_db)             state_nxt = DISCHARGE;
               else if (phase_timeout) state_nxt = REPORT;
            end
            DISCHARGE: if (!neg_db || phase_timeout) state_nxt = REPORT;
            REPORT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CHARGE, DISCHARGE: busy = 1'b1;
         REPORT:            done = 1'b1;
         default:           ;
      endcase
   end

   // Results are written from the cycle that ends a phase; the reported
   // count therefore includes that final cycle (cnt+1).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reference      <= 1'b0;
         cnt            <= '0;
         charge_time    <= '0;
         discharge_time <= '0;
         timeout_err    <= 1'b0;
         err_phase      <= 1'b0;
      end else begin
         reference <= (state_nxt == CHARGE);
         if (busy && (state_nxt == state)) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
         if (!host.abort) begin
            case (state)
               IDLE: begin
                  if (host.start) begin
                     charge_time    <= '0;
                     discharge_time <= '0;
                     timeout_err    <= 1'b0;
                  end
               end
               CHARGE: begin
                  if (pos_db) begin
                     charge_time <= cnt + 1'b1;
                  end else if (phase_timeout) begin
                     charge_time <= TIMEOUT_VAL;
                     timeout_err <= 1'b1;
                     err_phase   <= 1'b0;
                  end
               end
               DISCHARGE: begin
                  if (!neg_db) begin
                     discharge_time <= cnt + 1'b1;
                  end else if (phase_timeout) begin
                     discharge_time <= TIMEOUT_VAL;
                     timeout_err    <= 1'b1;
                     err_phase      <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign host.busy           = busy;
   assign host.done           = done;
   assign host.timeout_err    = timeout_err;
   assign host.err_phase      = err_phase;
   assign host.charge_time    = charge_time;
   assign host.discharge_time = discharge_time;

endmodule

// File: tb/tb_avk_cap_sequencer.sv
// Directed bench for avk_cap_sequencer with short debounce/timeout settings;
// expected measurement results are queued at start and checked on each done pulse.
module tb_avk_cap_sequencer;
   localparam int DEB = 16;
   localparam int TMO = 1000;
   localparam int CW  = 12;

   typedef struct packed {
      logic          terr;
      logic          ephase;
      logic [CW-1:0] ct;
      logic [CW-1:0] dt;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic pos   = 1'b0;
   logic neg   = 1'b1;
   logic reference;

   int total    = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   int done_cnt = 0;
   int exp_done = 0;
   exp_t sb_q[$];

   avk_cap_sequencer_if #(.CNT_W(CW)) host ();

   avk_cap_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO),
      .CNT_W           (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .host           (host),
      .pos_comparator (pos),
      .neg_comparator (neg),
      .reference      (reference)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (host.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic terr, input logic ephase, input int ct, input int dt);
      exp_t e;
      e.terr   = terr;
      e.ephase = ephase;
      e.ct     = CW'(ct);
      e.dt     = CW'(dt);
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input string tag, input int budget);
      exp_t e;
      bit   seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock);
         if (host.done === 1'b1) seen = 1;
      end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         exp_done++;
         check({tag, "_charge_time"}, 32'(host.charge_time), 32'(e.ct));
         check({tag, "_discharge_time"}, 32'(host.discharge_time), 32'(e.dt));
         check({tag, "_timeout_err"}, 32'(host.timeout_err), 32'(e.terr));
         if (e.terr) check({tag, "_err_phase"}, 32'(host.err_phase), 32'(e.ephase));
         check({tag, "_ref_at_done"}, 32'(reference), 32'd0);
         check({tag, "_busy_at_done"}, 32'(host.busy), 32'd0);
         @(negedge clock);
         check({tag, "_done_one_cycle"}, 32'(host.done), 32'd0);
      end
   endtask

   task automatic idle_comps();
      pos = 1'b0;
      neg = 1'b1;
      repeat (30) @(negedge clock);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      host.start = 1'b1;
      @(negedge clock);
      host.start = 1'b0;
   endtask

   // Raw pos is sampled p clocks after CHARGE entry, raw neg n clocks after
   // DISCHARGE entry; each phase then lasts sample offset + DEB + 2 cycles.
   task automatic run_meas(input string tag, input int p, input int n, input bit poke, input bit glitch);
      push_exp(1'b0, 1'b0, p + DEB + 2, n + DEB + 2);
      pulse_start();
      for (int c = 1; c <= p + DEB + 1 + n; c++) begin
         @(negedge clock);
         if (c == p - 2) check({tag, "_ref_in_charge"}, 32'(reference), 32'd1);
         if (c < p - 1)
            pos = glitch && (c >= 19) && ((((c - 19) / 5) % 2) == 0);
         else
            pos = 1'b1;
         if (c == p + DEB + 1 + n) neg = 1'b0;
         host.start = poke && (c == 10);
      end
      host.start = 1'b0;
      wait_done(tag, 200);
      idle_comps();
   endtask

   initial begin
      host.start = 1'b0;
      host.abort = 1'b0;

      // reset held with idle comparators
      #3;
      check("rst_reference", 32'(reference), 32'd0);
      check("rst_busy", 32'(host.busy), 32'd0);
      check("rst_done", 32'(host.done), 32'd0);
      check("rst_charge_time", 32'(host.charge_time), 32'd0);
      check("rst_discharge_time", 32'(host.discharge_time), 32'd0);
      check("rst_timeout_err", 32'(host.timeout_err), 32'd0);
      repeat (3) @(negedge clock);
      check("rst_held_busy", 32'(host.busy), 32'd0);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      check("post_rst_busy", 32'(host.busy), 32'd0);
      check("post_rst_reference", 32'(reference), 32'd0);
      check("post_rst_no_done", 32'(done_cnt), 32'd0);

      // clean measurement, with an ignored start mid-CHARGE
      run_meas("clean", 100, 50, 1'b1, 1'b0);

      // glitchy pos before final settle at cycle 80
      run_meas("glitch", 80, 50, 1'b0, 1'b1);

      // both conditions already true at phase entry
      pos = 1'b1;
      neg = 1'b0;
      repeat (30) @(negedge clock);
      push_exp(1'b0, 1'b0, 1, 1);
      pulse_start();
      wait_done("instant", 20);
      idle_comps();

      // charge timeout
      push_exp(1'b1, 1'b0, TMO, 0);
      pulse_start();
      wait_done("tmo_charge", TMO + 50);
      idle_comps();

      // discharge timeout
      push_exp(1'b1, 1'b1, 10 + DEB + 2, TMO);
      pulse_start();
      for (int c = 1; c <= 9; c++) @(negedge clock);
      pos = 1'b1;
      wait_done("tmo_discharge", TMO + 100);
      idle_comps();

      // start and abort together: abort wins
      @(negedge clock);
      host.start = 1'b1;
      host.abort = 1'b1;
      @(negedge clock);
      host.start = 1'b0;
      host.abort = 1'b0;
      check("start_abort_busy", 32'(host.busy), 32'd0);

      // abort at CHARGE cycle 40
      pulse_start();
      for (int c = 1; c <= 39; c++) begin
         @(negedge clock);
         host.start = (c == 10);
         if (c == 20) check("pre_abort_busy", 32'(host.busy), 32'd1);
      end
      host.abort = 1'b1;
      @(negedge clock);
      host.abort = 1'b0;
      check("abort_reference", 32'(reference), 32'd0);
      check("abort_busy", 32'(host.busy), 32'd0);
      repeat (30) @(negedge clock);
      check("abort_no_done", 32'(done_cnt), 32'(exp_done));
      run_meas("after_abort", 20, 5, 1'b0, 1'b0);

      // async reset in the middle of DISCHARGE
      pulse_start();
      for (int c = 1; c <= 39 + DEB + 2 + 10; c++) begin
         @(negedge clock);
         if (c == 39) pos = 1'b1;
      end
      check("mid_dis_charge_time", 32'(host.charge_time), 32'(40 + DEB + 2));
      check("mid_dis_busy", 32'(host.busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_reference", 32'(reference), 32'd0);
      check("async_rst_busy", 32'(host.busy), 32'd0);
      check("async_rst_charge_time", 32'(host.charge_time), 32'd0);
      check("async_rst_discharge_time", 32'(host.discharge_time), 32'd0);
      pos = 1'b0;
      neg = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      run_meas("after_reset", 30, 10, 1'b0, 1'b0);

      check("done_pulse_count", 32'(done_cnt), 32'(exp_done));
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
